dromajo_commit_queue: RTL

//  Buffers up to COMMIT_WIDTH retired instructions plus one trap per cycle from the core, and

---
 rtl/dromajo_commit_queue.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dromajo_commit_queue.sv
// Commit/trap queue feeding the Dromajo co-sim checker: packs up to COMMIT_WIDTH retires plus
// one trap per cycle into a circular buffer and replays them one entry per cycle.
module dromajo_commit_queue #(
   parameter int COMMIT_WIDTH = 2,
   parameter int XLEN         = 64,
   parameter int INST_LEN     = 32,
   parameter int DEPTH        = 16
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic [COMMIT_WIDTH-1:0]       valid,
   input  logic [XLEN*COMMIT_WIDTH-1:0]  pc,
   input  logic [INST_LEN*COMMIT_WIDTH-1:0] inst,
   input  logic [XLEN*COMMIT_WIDTH-1:0]  wdata,
   input  logic [XLEN*COMMIT_WIDTH-1:0]  mstatus,
   input  logic [COMMIT_WIDTH-1:0]       check,
   input  logic                          int_xcpt,
   input  logic [XLEN-1:0]               cause,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_kind,
   output logic [31:0]                   out_seq,
   output logic [XLEN-1:0]               out_pc,
   output logic [XLEN-1:0]               out_wdata,
   output logic [XLEN-1:0]               out_mstatus,
   output logic [INST_LEN-1:0]           out_inst,
   output logic                          out_check,
   output logic                          almost_full,
   output logic                          overflow,
   output logic [15:0]                   drop_count,
   output logic [$clog2(DEPTH):0]        count
);
   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;
   localparam int GRP  = COMMIT_WIDTH + 1;
   localparam int NW   = $clog2(GRP + 1);

   typedef struct packed {
      logic                kind;
      logic [31:0]         seq;
      logic [XLEN-1:0]     pc;
      logic [INST_LEN-1:0] inst;
      logic [XLEN-1:0]     wdata;
      logic [XLEN-1:0]     mstatus;
      logic                check;
   } entry_t;

   entry_t            mem_q [DEPTH];
   logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CNTW-1:0]   count_q, count_d, free_w;
   logic [31:0]       seq_q, seq_d;
   logic              ovf_q, ovf_d;
   logic [15:0]       drop_q, drop_d;

   entry_t            grp [GRP];
   logic [NW-1:0]     n_w;
   logic              admit_w, drop_w, pop_w;

   // Compact valid lanes in ascending order, trap last; seq is assigned speculatively.
   always_comb begin : grp_build
      int pos;
      pos = 0;
      for (int k = 0; k < GRP; k++) grp[k] = '0;
      if (enable) begin
         for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (valid[i]) begin
               grp[pos].kind    = 1'b0;
               grp[pos].seq     = seq_q + 32'(pos);
               grp[pos].pc      = pc[(i+1)*XLEN-1 -: XLEN];
               grp[pos].inst    = inst[(i+1)*INST_LEN-1 -: INST_LEN];
               grp[pos].wdata   = wdata[(i+1)*XLEN-1 -: XLEN];
               grp[pos].mstatus = mstatus[(i+1)*XLEN-1 -: XLEN];
               grp[pos].check   = check[i];
               pos = pos + 1;
            end
         end
         if (int_xcpt) begin
            grp[pos].kind  = 1'b1;
            grp[pos].seq   = seq_q + 32'(pos);
            grp[pos].wdata = cause;
            pos = pos + 1;
         end
      end
      n_w = NW'(pos);
   end

   // Admission sees pre-pop occupancy, so a full queue never admits even while draining.
   always_comb begin
      free_w  = CNTW'(DEPTH) - count_q;
      admit_w = (n_w != '0) && (CNTW'(n_w) <= free_w);
      drop_w  = (n_w != '0) && !admit_w;
      pop_w   = (count_q != '0) && out_ready;
      count_d = count_q + (admit_w ? CNTW'(n_w) : '0) - CNTW'(pop_w);
      tail_d  = tail_q + (admit_w ? AW'(n_w) : '0);
      head_d  = head_q + AW'(pop_w);
      seq_d   = seq_q + (admit_w ? 32'(n_w) : 32'd0);
      ovf_d   = ovf_q | drop_w;
      drop_d  = (drop_w && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         seq_q   <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         seq_q   <= seq_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   // Storage is cleared on reset so the head outputs read zero while empty after reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
      end else if (admit_w) begin
         for (int k = 0; k < GRP; k++)
            if (k < int'(n_w)) mem_q[tail_q + AW'(k)] <= grp[k];
      end
   end

   always_comb begin
      out_valid   = (count_q != '0);
      out_kind    = mem_q[head_q].kind;
      out_seq     = mem_q[head_q].seq;
      out_pc      = mem_q[head_q].pc;
      out_inst    = mem_q[head_q].inst;
      out_wdata   = mem_q[head_q].wdata;
      out_mstatus = mem_q[head_q].mstatus;
      out_check   = mem_q[head_q].check;
      almost_full = (CNTW'(DEPTH) - count_q) < CNTW'(2 * GRP);
      overflow    = ovf_q;
      drop_count  = drop_q;
      count       = count_q;
   end
endmodule
